// File: rtl/apb_ram_slave_pkg.sv
// Shared types and constants for the APB RAM completer.
// Provides the APB bus width macros (if the including codebase has not
// already defined them), mirrored as package localparams, the FSM state
// type, the default byte-offset width and a word-index width helper.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif
`ifndef APB_STRB_WIDTH
`define APB_STRB_WIDTH (`APB_DATA_WIDTH/8)
`endif
`ifndef APB_PROT_WIDTH
`define APB_PROT_WIDTH 3
`endif

package apb_ram_slave_pkg;
    localparam int APB_AW = `APB_ADDR_WIDTH;
    localparam int APB_DW = `APB_DATA_WIDTH;
    localparam int APB_SW = `APB_STRB_WIDTH;
    localparam int APB_PW = `APB_PROT_WIDTH;

    localparam int ADDR_LSB_DEF = 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Bits needed to index MEM_DEPTH words.
    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/apb_ram_slave_if.sv
// APB4 bus between a master and the RAM completer.
// master modport drives PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB/PPROT,
// slave modport drives PREADY/PRDATA/PSLVERR.
interface apb_ram_slave_if
    import apb_ram_slave_pkg::*;
    ;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [APB_AW-1:0] PADDR;
    logic [APB_DW-1:0] PWDATA;
    logic [APB_SW-1:0] PSTRB;
    logic [APB_PW-1:0] PPROT;
    logic              PREADY;
    logic [APB_DW-1:0] PRDATA;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_ram_slave_mem.sv
// Synchronous single-port, byte-enabled RAM.
// Ports: clk; we/be/idx/wdata write a word with per-byte enables;
// re loads rdata with the word at idx on the same edge (registered read).
// Contents are not reset.
module apb_ram_mem #(
    parameter  int MEM_DEPTH = 256,
    parameter  int DATA_W    = 32,
    localparam int IW        = $clog2(MEM_DEPTH),
    localparam int BW        = DATA_W / 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [BW-1:0]     be,
    input  logic [IW-1:0]     idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BW; i++) begin
                if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (re) rdata <= mem[idx];
    end
endmodule

// File: rtl/apb_ram_slave.sv
// APB4 completer backed by a word-organised, byte-strobed RAM with a
// programmable number of wait states and an error response for
// misaligned or out-of-range addresses.
// Ports: PCLK, PRESET (async, active-high), apb (slave modport:
// PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB/PPROT in; PREADY/PRDATA/PSLVERR out).
module apb_ram_slave
    import apb_ram_slave_pkg::*;
#(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_LSB    = ADDR_LSB_DEF
) (
    input logic          PCLK,
    input logic          PRESET,
    apb_ram_slave_if.slave apb
);
    localparam int IW = idx_width(MEM_DEPTH);
    localparam int HI = ADDR_LSB + IW;  // lowest address bit that is out of range
    localparam logic [APB_AW-1:0] LO_MASK = APB_AW'((64'd1 << ADDR_LSB) - 64'd1);

    state_t            state;
    logic [3:0]        cnt;
    logic              pwrite_q;
    logic [APB_AW-1:0] paddr_q;
    logic [APB_DW-1:0] pwdata_q;
    logic [APB_SW-1:0] pstrb_q;
    logic [APB_PW-1:0] pprot_q;
    logic              err_q;
    logic              ready_q;
    logic              slverr_q;
    logic              rd_ok;       // RESP of a good read: expose RAM data
    logic [APB_DW-1:0] mem_rdata;
    logic              addr_err;
    logic              setup;
    logic              access;
    logic              mem_we;
    logic              mem_re;
    logic [IW-1:0]     mem_idx;
    logic              unused_ok;

    assign setup    = apb.PSEL && !apb.PENABLE;
    assign access   = apb.PSEL && apb.PENABLE;
    assign addr_err = (|(apb.PADDR & LO_MASK)) || (|(apb.PADDR >> HI));

    // The RAM read is launched on the setup edge straight from the bus so
    // its registered output is ready by the first RESP cycle, even with no
    // wait states. Writes land on the edge that closes RESP, so the next
    // transfer's setup read (one edge later) already sees them.
    assign mem_re  = (state == IDLE) && setup;
    assign mem_we  = (state == RESP) && access && pwrite_q && !err_q;
    assign mem_idx = (state == IDLE) ? apb.PADDR[ADDR_LSB +: IW] : paddr_q[ADDR_LSB +: IW];

    apb_ram_mem #(.MEM_DEPTH(MEM_DEPTH), .DATA_W(APB_DW)) u_mem (
        .clk   (PCLK),
        .we    (mem_we),
        .re    (mem_re),
        .be    (pstrb_q),
        .idx   (mem_idx),
        .wdata (pwdata_q),
        .rdata (mem_rdata)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            cnt      <= '0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            pprot_q  <= '0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rd_ok    <= 1'b0;
        end else begin
            // Response outputs are single-cycle unless re-asserted below.
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rd_ok    <= 1'b0;
            case (state)
                IDLE: if (setup) begin
                    pwrite_q <= apb.PWRITE;
                    paddr_q  <= apb.PADDR;
                    pwdata_q <= apb.PWDATA;
                    pstrb_q  <= apb.PSTRB;
                    pprot_q  <= apb.PPROT;
                    err_q    <= addr_err;
                    if (WAIT_CYCLES == 0) begin
                        state    <= RESP;
                        ready_q  <= 1'b1;
                        slverr_q <= addr_err;
                        rd_ok    <= !apb.PWRITE && !addr_err;
                    end else begin
                        state <= WAIT;
                        cnt   <= 4'(WAIT_CYCLES);
                    end
                end
                WAIT: begin
                    if (!apb.PSEL) begin
                        state <= IDLE;
                    end else if (apb.PENABLE) begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state    <= RESP;
                            ready_q  <= 1'b1;
                            slverr_q <= err_q;
                            rd_ok    <= !pwrite_q && !err_q;
                        end
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign apb.PREADY  = ready_q;
    assign apb.PSLVERR = slverr_q;
    assign apb.PRDATA  = rd_ok ? mem_rdata : '0;

    // PPROT and the non-index address bits are held but have no function.
    assign unused_ok = ^{pprot_q, paddr_q};
endmodule

// File: tb/tb_apb_ram_slave.sv
module tb_apb_ram_slave;
    import apb_ram_slave_pkg::*;

    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    always #5 PCLK = ~PCLK;

    logic        sel0, sel1, en, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;

    apb_ram_slave_if b0 ();
    apb_ram_slave_if b1 ();

    assign b0.PSEL = sel0;  assign b0.PENABLE = en;  assign b0.PWRITE = wr;
    assign b0.PADDR = addr; assign b0.PWDATA = wdata; assign b0.PSTRB = strb;
    assign b0.PPROT = prot;
    assign b1.PSEL = sel1;  assign b1.PENABLE = en;  assign b1.PWRITE = wr;
    assign b1.PADDR = addr; assign b1.PWDATA = wdata; assign b1.PSTRB = strb;
    assign b1.PPROT = prot;

    apb_ram_slave #(.MEM_DEPTH(256), .WAIT_CYCLES(0), .ADDR_LSB(2)) dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .apb(b0));
    apb_ram_slave #(.MEM_DEPTH(256), .WAIT_CYCLES(3), .ADDR_LSB(2)) dut1 (
        .PCLK(PCLK), .PRESET(PRESET), .apb(b1));

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m0 [256];
    logic [31:0] m1 [256];

    typedef struct {
        int          d;
        bit          w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [31:0] erd;
        bit          eerr;
    } vec_t;
    vec_t tbl[$];

    function automatic logic rdy(input int d);
        return (d != 0) ? b1.PREADY : b0.PREADY;
    endfunction
    function automatic logic [31:0] rdat(input int d);
        return (d != 0) ? b1.PRDATA : b0.PRDATA;
    endfunction
    function automatic logic serr(input int d);
        return (d != 0) ? b1.PSLVERR : b0.PSLVERR;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: 256 words at 4-byte granularity; anything else is an error.
    task automatic model(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st, output logic [31:0] erd, output logic eerr);
        int i;
        logic [31:0] word;
        eerr = (a % 4 != 0) || (a >= 32'h400);
        erd  = '0;
        if (!eerr) begin
            i = int'(a / 4);
            word = (d != 0) ? m1[i] : m0[i];
            if (!w) erd = word;
            else begin
                for (int b = 0; b < 4; b++) if (st[b]) word[b*8 +: 8] = wd[b*8 +: 8];
                if (d != 0) m1[i] = word; else m0[i] = word;
            end
        end
    endtask

    // One transfer; the setup phase starts in the cycle after the caller
    // returns, so consecutive calls are back-to-back.
    task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output logic er,
                        output int waits);
        rd = '0; er = 1'b0; waits = 0;
        @(posedge PCLK); #1;
        sel0 = (d == 0); sel1 = (d != 0); en = 1'b0;
        wr = w; addr = a; wdata = wd; strb = st; prot = 3'($urandom);
        @(negedge PCLK);
        chk($sformatf("setup_noready@%h", a), rdy(d), 1'b0);
        @(posedge PCLK); #1;
        en = 1'b1;
        forever begin
            @(negedge PCLK);
            if (rdy(d)) begin
                rd = rdat(d); er = serr(d);
                break;
            end
            waits++;
            if (waits > 40) begin
                chk("pready_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge PCLK); #1;
        end
    endtask

    task automatic mx(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input bit c);
        logic [31:0] erd, ard;
        logic eer, aer;
        int wt;
        model(d, w, a, wd, st, erd, eer);
        xfer(d, w, a, wd, st, ard, aer, wt);
        if (c) begin
            chk($sformatf("d%0d_rdata@%h", d, a), ard, erd);
            chk($sformatf("d%0d_pslverr@%h", d, a), 32'(aer), 32'(eer));
            chk($sformatf("d%0d_waits@%h", d, a), wt, (d != 0) ? 3 : 0);
        end
    endtask

    task automatic go_idle();
        @(posedge PCLK); #1;
        sel0 = 1'b0; sel1 = 1'b0; en = 1'b0;
        @(negedge PCLK);
        chk("idle_ready0", rdy(0), 1'b0);
        chk("idle_ready1", rdy(1), 1'b0);
    endtask

    initial begin
        logic [31:0] ard, erd, r;
        logic aer, eer;
        int wt, dd, seen;
        sel0 = 0; sel1 = 0; en = 0; wr = 0; addr = 0; wdata = 0; strb = 0; prot = 0;

        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_pready%0d", d), rdy(d), 1'b0);
            chk($sformatf("rst_prdata%0d", d), rdat(d), 32'h0);
            chk($sformatf("rst_pslverr%0d", d), serr(d), 1'b0);
        end
        @(posedge PCLK); #1;
        PRESET = 1'b0;

        //           d  w  addr        wdata         strb  exp rdata     err
        tbl.push_back('{0, 1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0,        0});
        tbl.push_back('{0, 0, 32'h010, 32'h0,        4'h0, 32'hDEADBEEF, 0});
        tbl.push_back('{1, 1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0,        0});
        tbl.push_back('{1, 0, 32'h010, 32'h0,        4'hA, 32'hDEADBEEF, 0});
        tbl.push_back('{0, 1, 32'h020, 32'h11223344, 4'hF, 32'h0,        0});
        tbl.push_back('{0, 1, 32'h020, 32'hAABBCCDD, 4'h5, 32'h0,        0});
        tbl.push_back('{0, 0, 32'h020, 32'h0,        4'h0, 32'h11BB33DD, 0});
        tbl.push_back('{0, 0, 32'h402, 32'h0,        4'h0, 32'h0,        1});
        tbl.push_back('{0, 1, 32'h000, 32'hCAFEF00D, 4'hF, 32'h0,        0});
        tbl.push_back('{0, 1, 32'h400, 32'h12345678, 4'hF, 32'h0,        1});
        tbl.push_back('{0, 0, 32'h000, 32'h0,        4'h0, 32'hCAFEF00D, 0});
        tbl.push_back('{0, 1, 32'h004, 32'h5A5A5A5A, 4'hF, 32'h0,        0});
        tbl.push_back('{0, 0, 32'h004, 32'h0,        4'h0, 32'h5A5A5A5A, 0});
        tbl.push_back('{0, 1, 32'h008, 32'h01020304, 4'hF, 32'h0,        0});
        tbl.push_back('{0, 1, 32'h008, 32'hFFFFFFFF, 4'h0, 32'h0,        0});
        tbl.push_back('{0, 0, 32'h008, 32'h0,        4'h0, 32'h01020304, 0});
        tbl.push_back('{1, 0, 32'h800, 32'h0,        4'h0, 32'h0,        1});
        tbl.push_back('{1, 1, 32'h3FD, 32'h0,        4'hF, 32'h0,        1});

        foreach (tbl[k]) begin
            xfer(tbl[k].d, tbl[k].w, tbl[k].a, tbl[k].wd, tbl[k].st, ard, aer, wt);
            chk($sformatf("tbl%0d_rdata", k), ard, tbl[k].erd);
            chk($sformatf("tbl%0d_pslverr", k), 32'(aer), 32'(tbl[k].eerr));
            chk($sformatf("tbl%0d_waits", k), wt, (tbl[k].d != 0) ? 3 : 0);
        end
        go_idle();

        // Fill both RAMs so every later read has a known reference value.
        for (int i = 0; i < 256; i++) begin
            mx(0, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0);
            mx(1, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0);
        end
        go_idle();

        for (int n = 0; n < 300; n++) begin
            dd = int'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       r = 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
                1:       r = ($urandom & 32'hFFFF_FFFC) | 32'h400;
                default: r = 32'($urandom_range(0, 15) * 4);
            endcase
            mx(dd, 1'($urandom), r, $urandom, 4'($urandom), 1'b1);
            if ($urandom_range(0, 7) == 0) go_idle();
        end
        go_idle();

        // Abort in WAIT: PSEL drops after one access cycle, write must not land.
        @(posedge PCLK); #1;
        sel1 = 1; en = 0; wr = 1; addr = 32'h30; wdata = ~m1[12]; strb = 4'hF;
        @(posedge PCLK); #1; en = 1;
        @(posedge PCLK); #1; sel1 = 0; en = 0;
        @(negedge PCLK);
        chk("abort_wait_ready", rdy(1), 1'b0);
        mx(1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b1);

        // Abort in RESP (zero-wait): PSEL low at the closing edge, no write.
        @(posedge PCLK); #1;
        sel0 = 1; sel1 = 0; en = 0; wr = 1; addr = 32'h38; wdata = ~m0[14]; strb = 4'hF;
        @(posedge PCLK); #1; sel0 = 0; en = 0;
        @(negedge PCLK);
        chk("abort_resp_ready", rdy(0), 1'b1);
        mx(0, 1'b0, 32'h38, 32'h0, 4'h0, 1'b1);

        // Reset during RESP of a read: outputs clear at once.
        model(1, 1'b0, 32'h34, 32'h0, 4'h0, erd, eer);
        @(posedge PCLK); #1;
        sel0 = 0; sel1 = 1; en = 0; wr = 0; addr = 32'h34; strb = 4'h0;
        @(posedge PCLK); #1; en = 1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge PCLK);
            if (rdy(1)) begin seen = 1; break; end
            @(posedge PCLK); #1;
        end
        chk("resp_seen", 32'(seen), 32'd1);
        chk("resp_prdata", rdat(1), erd);
        #1 PRESET = 1'b1;
        #1;
        chk("rst_resp_pready", rdy(1), 1'b0);
        chk("rst_resp_prdata", rdat(1), 32'h0);
        chk("rst_resp_pslverr", serr(1), 1'b0);
        sel1 = 0; en = 0;
        @(posedge PCLK); #1 PRESET = 1'b0;

        // Reset mid-WAIT on a write: the pending write is dropped.
        @(posedge PCLK); #1;
        sel1 = 1; en = 0; wr = 1; addr = 32'h34; wdata = ~m1[13]; strb = 4'hF;
        @(posedge PCLK); #1; en = 1;
        @(posedge PCLK); #3 PRESET = 1'b1;
        #1;
        chk("rst_wait_pready", rdy(1), 1'b0);
        chk("rst_wait_prdata", rdat(1), 32'h0);
        chk("rst_wait_pslverr", serr(1), 1'b0);
        sel1 = 0; en = 0;
        @(posedge PCLK); #1 PRESET = 1'b0;
        mx(1, 1'b0, 32'h34, 32'h0, 4'h0, 1'b1);
        mx(0, 1'b0, 32'h38, 32'h0, 4'h0, 1'b1);
        go_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
